// File: rtl/seg7_display_arbiter_if.sv
// Bus between the debug-tap side and the seven-segment display arbiter.
// The master drives status sources and message requests; the slave returns display words.
interface seg7_display_arbiter_if;
    logic [3:0]   src_valid;
    logic [127:0] src_data;
    logic         freeze;
    logic         msg_req;
    logic [31:0]  msg_data;
    logic         msg_ack;
    logic [31:0]  disp_data;
    logic [2:0]   disp_src;
    logic         disp_blank;

    modport master (
        output src_valid, src_data, freeze, msg_req, msg_data,
        input  msg_ack, disp_data, disp_src, disp_blank
    );

    modport slave (
        input  src_valid, src_data, freeze, msg_req, msg_data,
        output msg_ack, disp_data, disp_src, disp_blank
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin time-sharing of one 4-digit seven-segment display between four
// status sources, with a one-shot pre-empting message and a freeze control.
module seg7_display_arbiter #(
    parameter int unsigned DWELL    = 200000000,
    parameter int unsigned MSG_HOLD = 300000000,
    parameter int unsigned CNT_W    = 32
) (
    input logic                   clk,
    input logic                   rst,
    seg7_display_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHOW, MSG} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MSG_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       saved_q, saved_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [31:0]      disp_data_q;
    logic [2:0]       disp_src_q;
    logic             disp_blank_q;
    logic             msg_ack_q;
    logic [2:0]       nx_cur, nx_saved, first_vld;

    // {found, index} of the first valid source in order base+1, base+2, base+3, base
    function automatic logic [2:0] next_after(input logic [3:0] v, input logic [1:0] base);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign nx_cur    = next_after(bus.src_valid, cur_q);
    assign nx_saved  = next_after(bus.src_valid, saved_q);
    assign first_vld = next_after(bus.src_valid, 2'd3);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        saved_d = saved_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.msg_req) begin
                    accept = 1'b1;
                end else if (first_vld[2]) begin
                    state_d = SHOW;
                    cur_d   = first_vld[1:0];
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (bus.msg_req) begin
                    accept = 1'b1;
                end else if (!bus.src_valid[cur_q]) begin
                    // A vanished source moves on even while frozen
                    cnt_d = '0;
                    if (nx_cur[2]) cur_d = nx_cur[1:0];
                    else           state_d = IDLE;
                end else if (!bus.freeze) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        cur_d = nx_cur[1:0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MSG: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (bus.src_valid[saved_q]) begin
                        state_d = SHOW;
                        cur_d   = saved_q;
                    end else if (nx_saved[2]) begin
                        state_d = SHOW;
                        cur_d   = nx_saved[1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Message acceptance overrides any same-cycle rotation or drop
        if (accept) begin
            state_d = MSG;
            cnt_d   = '0;
            saved_d = cur_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            cnt_q        <= '0;
            saved_q      <= '0;
            disp_data_q  <= '0;
            disp_src_q   <= 3'd7;
            disp_blank_q <= 1'b1;
            msg_ack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            saved_q   <= saved_d;
            msg_ack_q <= accept;
            case (state_d)
                MSG: begin
                    if (accept) disp_data_q <= bus.msg_data;
                    disp_src_q   <= 3'd4;
                    disp_blank_q <= 1'b0;
                end
                SHOW: begin
                    disp_data_q  <= bus.src_data[32*cur_d +: 32];
                    disp_src_q   <= {1'b0, cur_d};
                    disp_blank_q <= 1'b0;
                end
                default: begin
                    disp_data_q  <= '0;
                    disp_src_q   <= 3'd7;
                    disp_blank_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.msg_ack    = msg_ack_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_src   = disp_src_q;
    assign bus.disp_blank = disp_blank_q;
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scenario tasks plus a randomized run, all compared against a cycle model of
// who should be on the display.
module tb_seg7_display_arbiter;
    localparam int DWELL = 8;
    localparam int HOLD  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seg7_display_arbiter_if vif();

    seg7_display_arbiter #(.DWELL(DWELL), .MSG_HOLD(HOLD), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    // Model: who is showing (-1 none, 0..3 source, 4 message) and for how long
    int          m_who = -1, m_cur = 0, m_saved = 0, m_t = 0, m_n;
    logic [31:0] m_msgw = '0;
    logic        exp_ack = 1'b0;
    logic [2:0]  exp_src = 3'd7;
    logic        exp_blank = 1'b1;
    logic [31:0] exp_data = '0;

    function automatic int pick(input logic [3:0] v, input int base);
        for (int k = 1; k <= 4; k++)
            if (v[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        exp_ack = 1'b0;
        if (rst) begin
            m_who = -1; m_cur = 0; m_saved = 0; m_t = 0;
        end else if (m_who != 4 && vif.msg_req) begin
            exp_ack = 1'b1; m_saved = m_cur; m_msgw = vif.msg_data; m_who = 4; m_t = 0;
        end else if (m_who == -1) begin
            m_n = pick(vif.src_valid, 3);
            if (m_n >= 0) begin m_cur = m_n; m_who = m_n; m_t = 0; end
        end else if (m_who == 4) begin
            if (m_t == HOLD - 1) begin
                m_t = 0;
                m_n = vif.src_valid[m_saved] ? m_saved : pick(vif.src_valid, m_saved);
                if (m_n < 0) m_who = -1;
                else begin m_cur = m_n; m_who = m_n; end
            end else m_t++;
        end else if (!vif.src_valid[m_cur]) begin
            m_t = 0;
            m_n = pick(vif.src_valid, m_cur);
            if (m_n < 0) m_who = -1;
            else begin m_cur = m_n; m_who = m_n; end
        end else if (!vif.freeze) begin
            if (m_t == DWELL - 1) begin
                m_t = 0; m_cur = pick(vif.src_valid, m_cur); m_who = m_cur;
            end else m_t++;
        end
        if (m_who == 4) begin
            exp_src = 3'd4; exp_blank = 1'b0; exp_data = m_msgw;
        end else if (m_who < 0) begin
            exp_src = 3'd7; exp_blank = 1'b1; exp_data = '0;
        end else begin
            exp_src = 3'(m_cur); exp_blank = 1'b0; exp_data = vif.src_data[m_cur*32 +: 32];
        end
    end

    function automatic logic [36:0] got_v();
        return {vif.msg_ack, vif.disp_src, vif.disp_blank, vif.disp_data};
    endfunction

    function automatic logic [36:0] exp_v();
        return {exp_ack, exp_src, exp_blank, exp_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.src_valid = '0; vif.src_data = '0; vif.freeze = 1'b0;
        vif.msg_req = 1'b0; vif.msg_data = '0;
        tick(); tick();
        checks++;
        if (got_v() !== {1'b0, 3'd7, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", got_v(), {1'b0, 3'd7, 1'b1, 32'h0});
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        vif.src_data = {32'h33333333, 32'h22222222, 32'h55555555, 32'h11111111};
        vif.src_valid = 4'b0101;
        tick();
        checks++;
        if ({vif.disp_src, vif.disp_data} !== {3'd0, 32'h11111111}) begin
            failures++;
            $display("FAIL rot_first got src=%0d data=%h want src=0 data=11111111", vif.disp_src, vif.disp_data);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DWELL; i++) begin
                tick();
                checks++;
                if (got_v() !== exp_v()) begin
                    failures++;
                    $display("FAIL rot_model got=%h want=%h", got_v(), exp_v());
                end
            end
            checks++;
            if (vif.disp_src !== ((r == 0) ? 3'd2 : 3'd0)) begin
                failures++;
                $display("FAIL rot_step%0d got src=%0d want=%0d", r, vif.disp_src, (r == 0) ? 2 : 0);
            end
        end
    endtask

    task automatic test_drop();
        repeat (DWELL + 3) tick();
        vif.src_valid = 4'b0001;
        tick();
        checks++;
        if (vif.disp_src !== 3'd0) begin
            failures++;
            $display("FAIL drop_switch got src=%0d want=0", vif.disp_src);
        end
        vif.src_valid = 4'b0101;
        for (int i = 0; i < DWELL; i++) begin
            tick();
            checks++;
            if (vif.disp_src !== ((i == DWELL - 1) ? 3'd2 : 3'd0) || got_v() !== exp_v()) begin
                failures++;
                $display("FAIL drop_dwell i=%0d got=%h want=%h", i, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_msg();
        repeat (DWELL) tick();
        vif.msg_req = 1'b1; vif.msg_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (got_v() !== {1'b1, 3'd4, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL msg_accept got=%h want=%h", got_v(), {1'b1, 3'd4, 1'b0, 32'hDEADBEEF});
        end
        vif.msg_req = 1'b0; vif.msg_data = 32'h12345678;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            checks++;
            if (got_v() !== {1'b0, 3'd4, 1'b0, 32'hDEADBEEF}) begin
                failures++;
                $display("FAIL msg_hold i=%0d got=%h want=%h", i, got_v(), {1'b0, 3'd4, 1'b0, 32'hDEADBEEF});
            end
        end
        tick();
        checks++;
        if (got_v() !== {1'b0, 3'd0, 1'b0, 32'h11111111}) begin
            failures++;
            $display("FAIL msg_return got=%h want=%h", got_v(), {1'b0, 3'd0, 1'b0, 32'h11111111});
        end
    endtask

    task automatic test_freeze();
        vif.freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (vif.disp_src !== 3'd0 || got_v() !== exp_v()) begin
                failures++;
                $display("FAIL freeze_pin i=%0d got=%h want=%h", i, got_v(), exp_v());
            end
        end
        vif.freeze = 1'b0;
        repeat (DWELL - 1) tick();
        checks++;
        if (vif.disp_src !== 3'd0) begin
            failures++;
            $display("FAIL freeze_remaining got src=%0d want=0", vif.disp_src);
        end
        tick();
        checks++;
        if (vif.disp_src !== 3'd2) begin
            failures++;
            $display("FAIL freeze_release got src=%0d want=2", vif.disp_src);
        end
        vif.freeze = 1'b1; vif.msg_req = 1'b1; vif.msg_data = 32'hCAFEF00D;
        tick();
        vif.msg_req = 1'b0;
        checks++;
        if (got_v() !== {1'b1, 3'd4, 1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL freeze_msg got=%h want=%h", got_v(), {1'b1, 3'd4, 1'b0, 32'hCAFEF00D});
        end
        repeat (HOLD) tick();
        checks++;
        if (got_v() !== {1'b0, 3'd2, 1'b0, 32'h22222222}) begin
            failures++;
            $display("FAIL freeze_msg_end got=%h want=%h", got_v(), {1'b0, 3'd2, 1'b0, 32'h22222222});
        end
        vif.freeze = 1'b0;
    endtask

    task automatic test_msg_to_idle();
        vif.msg_req = 1'b1; vif.msg_data = 32'hA5A5A5A5;
        tick();
        vif.msg_req = 1'b0; vif.src_valid = 4'b0000;
        repeat (HOLD - 1) tick();
        checks++;
        if (vif.disp_src !== 3'd4) begin
            failures++;
            $display("FAIL idle_hold got src=%0d want=4", vif.disp_src);
        end
        tick();
        checks++;
        if (got_v() !== {1'b0, 3'd7, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL idle_blank got=%h want=%h", got_v(), {1'b0, 3'd7, 1'b1, 32'h0});
        end
    endtask

    task automatic test_reset_mid_msg();
        vif.msg_req = 1'b1; vif.msg_data = 32'h0BADF00D;
        tick();
        vif.msg_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (got_v() !== {1'b0, 3'd7, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL rst_mid_msg got=%h want=%h", got_v(), {1'b0, 3'd7, 1'b1, 32'h0});
        end
        rst = 1'b0; vif.src_valid = 4'b1000;
        tick();
        checks++;
        if (got_v() !== {1'b0, 3'd3, 1'b0, 32'h33333333}) begin
            failures++;
            $display("FAIL rst_recover got=%h want=%h", got_v(), {1'b0, 3'd3, 1'b0, 32'h33333333});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15) == 0) vif.src_valid = 4'($urandom);
            if ($urandom_range(7) == 0) vif.freeze = ~vif.freeze;
            if ($urandom_range(3) == 0) vif.src_data = {$urandom, $urandom, $urandom, $urandom};
            vif.msg_data = $urandom;
            if (vif.msg_req && vif.msg_ack && $urandom_range(1) == 0) vif.msg_req = 1'b0;
            else if (!vif.msg_req && $urandom_range(30) == 0) vif.msg_req = 1'b1;
            rst = ($urandom_range(499) == 0);
            tick();
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL random c=%0d got=%h want=%h", c, got_v(), exp_v());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_drop();
        test_msg();
        test_freeze();
        test_msg_to_idle();
        test_reset_mid_msg();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
